// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store sequencer between execute and Memory.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses are rejected with resp_error.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wr_data,
   output logic        mem_wr_enable,
   output logic [2:0]  mem_write_length,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_wr_data_q, mem_wr_data_d;
   logic        mem_wr_enable_q, mem_wr_enable_d;
   logic [2:0]  mem_write_length_q, mem_write_length_d;

   logic        req_funct3_ok;
   logic        req_misaligned;
   logic        req_legal;

   function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
         3'b100, 3'b101:         funct3_legal = ~store;
         default:                funct3_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rd);
      case (f3)
         3'b000:  load_extend = {{24{rd[7]}}, rd[7:0]};
         3'b001:  load_extend = {{16{rd[15]}}, rd[15:0]};
         3'b010:  load_extend = rd;
         3'b100:  load_extend = {24'd0, rd[7:0]};
         3'b101:  load_extend = {16'd0, rd[15:0]};
         default: load_extend = 32'd0;
      endcase
   endfunction

   assign req_funct3_ok = funct3_legal(req_store, req_funct3);

`ifdef MISALIGN_TRAP_EN
   assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif

   assign req_legal = req_funct3_ok & ~req_misaligned;

   always_comb begin
      state_d            = state_q;
      store_d            = store_q;
      funct3_d           = funct3_q;
      rdata_d            = rdata_q;
      error_d            = error_q;
      mem_address_d      = mem_address_q;
      mem_wr_data_d      = mem_wr_data_q;
      mem_write_length_d = mem_write_length_q;
      mem_wr_enable_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               rdata_d  = 32'd0;
               if (req_legal) begin
                  // Memory-facing registers are loaded here so they are valid
                  // for the whole ACCESS cycle; rejected requests leave them untouched.
                  error_d            = 1'b0;
                  mem_address_d      = req_addr;
                  mem_write_length_d = {1'b0, req_funct3[1:0]};
                  mem_wr_enable_d    = req_store;
                  if (req_store) begin
                     mem_wr_data_d = req_wdata;
                  end
                  state_d = ACCESS;
               end else begin
                  error_d = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            if (!store_q) begin
               rdata_d = load_extend(funct3_q, mem_read_data);
            end
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Async reset also drops mem_wr_enable mid-ACCESS, cancelling the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= IDLE;
         store_q            <= 1'b0;
         funct3_q           <= 3'd0;
         rdata_q            <= 32'd0;
         error_q            <= 1'b0;
         mem_address_q      <= 32'd0;
         mem_wr_data_q      <= 32'd0;
         mem_wr_enable_q    <= 1'b0;
         mem_write_length_q <= 3'd0;
      end else begin
         state_q            <= state_d;
         store_q            <= store_d;
         funct3_q           <= funct3_d;
         rdata_q            <= rdata_d;
         error_q            <= error_d;
         mem_address_q      <= mem_address_d;
         mem_wr_data_q      <= mem_wr_data_d;
         mem_wr_enable_q    <= mem_wr_enable_d;
         mem_write_length_q <= mem_write_length_d;
      end
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = (state_q == RESP);
   assign resp_rdata       = rdata_q;
   assign resp_error       = error_q;
   assign mem_address      = mem_address_q;
   assign mem_wr_data      = mem_wr_data_q;
   assign mem_wr_enable    = mem_wr_enable_q;
   assign mem_write_length = mem_write_length_q;

`ifndef SYNTHESIS
   a_we_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
      mem_wr_enable_q |-> (state_q == ACCESS) && store_q);
   a_error_no_data: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid && resp_error) |-> (resp_rdata == 32'd0));
`endif

endmodule
